// File: rtl/time_digit_writer_pkg.sv
// Shared definitions for the clock-time display writer.
// Contents:
//   - bit positions of each BCD field inside the 20-bit packed time
//   - the digit index enum (DIG_S1..DIG_H2)
//   - the LCD column offset of each digit, relative to the H2 column
//   - the ASCII codes used on the display
//   - the writer FSM state type
//   - field_of(): extracts one zero-extended digit field from the packed time
package time_disp_pkg;

    localparam int S1_LSB = 0;
    localparam int S1_MSB = 3;
    localparam int S2_LSB = 4;
    localparam int S2_MSB = 6;
    localparam int M1_LSB = 7;
    localparam int M1_MSB = 10;
    localparam int M2_LSB = 11;
    localparam int M2_MSB = 13;
    localparam int H1_LSB = 14;
    localparam int H1_MSB = 17;
    localparam int H2_LSB = 18;
    localparam int H2_MSB = 19;

    typedef enum logic [2:0] {
        DIG_S1 = 3'd0,
        DIG_S2 = 3'd1,
        DIG_M1 = 3'd2,
        DIG_M2 = 3'd3,
        DIG_H1 = 3'd4,
        DIG_H2 = 3'd5
    } digit_e;

    // Column offset per digit index; "HH:MM:SS" leaves gaps at +2 and +5
    // for the colons. Index 5 (H2) is the leftmost entry.
    localparam logic [5:0][2:0] COL_OFS = {3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd7};

    localparam logic [7:0] CH_ZERO    = 8'h30;
    localparam logic [7:0] CH_COLON   = 8'h3A;
    localparam logic [7:0] CH_SPACE   = 8'h20;
    localparam logic [7:0] CH_UNKNOWN = 8'h3F;

    typedef enum logic [2:0] {
        ST_INIT_C0 = 3'd0,
        ST_INIT_C1 = 3'd1,
        ST_LOAD    = 3'd2,
        ST_SEND    = 3'd3,
        ST_IDLE    = 3'd4
    } state_e;

    function automatic logic [3:0] field_of(input logic [19:0] t, input digit_e d);
        case (d)
            DIG_S1:  field_of = t[S1_MSB:S1_LSB];
            DIG_S2:  field_of = {1'b0, t[S2_MSB:S2_LSB]};
            DIG_M1:  field_of = t[M1_MSB:M1_LSB];
            DIG_M2:  field_of = {1'b0, t[M2_MSB:M2_LSB]};
            DIG_H1:  field_of = t[H1_MSB:H1_LSB];
            DIG_H2:  field_of = {2'b00, t[H2_MSB:H2_LSB]};
            default: field_of = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/time_digit_writer_if.sv
// Character-write handshake towards the LCD character driver.
//   valid : a character write is pending (held until ready)
//   pos   : target column
//   ch    : ASCII code
//   ready : driver accepts the character this cycle
// master = writer side, slave = LCD driver side.
interface time_digit_writer_if #(
    parameter int POS_W = 4
) ();
    logic             valid;
    logic [POS_W-1:0] pos;
    logic [7:0]       ch;
    logic             ready;

    modport master (output valid, output pos, output ch, input ready);
    modport slave  (input valid, input pos, input ch, output ready);
endinterface

// File: rtl/time_digit_writer_bcd_to_ascii.sv
// Converts one digit field (already zero-extended to 4 bits) to ASCII.
//   digit      : field value
//   blank_zero : render a zero as a space instead of '0'
//   ascii      : '0'..'9', ' ' for a blanked zero, '?' for any value above 9
module bcd_to_ascii
    import time_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank_zero,
    output logic [7:0] ascii
);

    // Digit to character, out-of-range values take priority over blanking
    always_comb begin
        ascii = CH_UNKNOWN;
        if (digit > 4'd9) begin
            ascii = CH_UNKNOWN;
        end else if (blank_zero && (digit == 4'd0)) begin
            ascii = CH_SPACE;
        end else begin
            ascii = CH_ZERO + {4'd0, digit};
        end
    end

endmodule

// File: rtl/time_digit_writer.sv
// Writes the "HH:MM:SS" time onto an LCD, one character per changed digit.
// After reset both ':' separators are painted, then all six digits.
// Afterwards each i_time_wr_en strobe marks digits (i_time_sel) for rewrite
// from the newest snapshot of i_time_read_time; digits go out highest first
// (H2,H1,M2,M1,S2,S1) over a valid/ready handshake.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_time_wr_en      : strobe qualifying i_time_sel / i_time_read_time
//   i_time_sel        : changed-digit mask, bit0=S1 .. bit5=H2
//   i_time_read_time  : packed BCD time
//   i_lcd_ready       : LCD driver accepts the presented character
//   o_lcd_valid/pos/char : character write request (registered)
//   o_busy            : low only when nothing is pending or in flight
// Optional build macro: LEADING_ZERO_BLANK_EN renders an H2 of zero as ' '.
module time_digit_writer
    import time_disp_pkg::*;
#(
    parameter int COL_BASE = 4,
    parameter int POS_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_time_wr_en,
    input  logic [5:0]       i_time_sel,
    input  logic [19:0]      i_time_read_time,
    input  logic             i_lcd_ready,
    output logic             o_lcd_valid,
    output logic [POS_W-1:0] o_lcd_pos,
    output logic [7:0]       o_lcd_char,
    output logic             o_busy
);

    if ((COL_BASE + 7) >= (1 << POS_W)) begin : g_cfg_check
        $error("time_digit_writer: COL_BASE+7 does not fit in POS_W bits");
    end

    localparam logic [POS_W-1:0] COLON0_POS = POS_W'(COL_BASE + 2);
    localparam logic [POS_W-1:0] COLON1_POS = POS_W'(COL_BASE + 5);

    state_e           state_r, state_nxt_s;
    logic [5:0]       pending_r, pending_nxt_s;
    logic [19:0]      snapshot_r;
    logic             valid_r, valid_nxt_s;
    logic [POS_W-1:0] pos_r, pos_nxt_s;
    logic [7:0]       char_r, char_nxt_s;
    logic             busy_r;

    digit_e           load_dig_s;
    logic [5:0]       load_bit_s;
    logic [5:0]       clr_bit_s;
    logic [3:0]       load_field_s;
    logic             load_blank_s;
    logic [7:0]       load_char_s;
    logic [POS_W-1:0] load_pos_s;
    logic             xfer_s;

    assign xfer_s = valid_r & i_lcd_ready;

    // Highest pending digit wins; H2 is the most significant mask bit
    always_comb begin
        load_dig_s = DIG_S1;
        casez (pending_r)
            6'b1?????: load_dig_s = DIG_H2;
            6'b01????: load_dig_s = DIG_H1;
            6'b001???: load_dig_s = DIG_M2;
            6'b0001??: load_dig_s = DIG_M1;
            6'b00001?: load_dig_s = DIG_S2;
            6'b000001: load_dig_s = DIG_S1;
            default:   load_dig_s = DIG_S1;
        endcase
    end

    assign load_bit_s   = 6'b000001 << load_dig_s;
    assign load_field_s = field_of(snapshot_r, load_dig_s);
    assign load_pos_s   = POS_W'(COL_BASE) + POS_W'(COL_OFS[load_dig_s]);

`ifdef LEADING_ZERO_BLANK_EN
    assign load_blank_s = (load_dig_s == DIG_H2);
`else
    assign load_blank_s = 1'b0;
`endif

    bcd_to_ascii u_bcd_to_ascii (
        .digit      (load_field_s),
        .blank_zero (load_blank_s),
        .ascii      (load_char_s)
    );

    // Next state and next registered outputs of the write sequencer
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = valid_r;
        pos_nxt_s   = pos_r;
        char_nxt_s  = char_r;
        clr_bit_s   = 6'b000000;
        case (state_r)
            ST_INIT_C0: begin
                valid_nxt_s = 1'b1;
                char_nxt_s  = CH_COLON;
                if (xfer_s) begin
                    state_nxt_s = ST_INIT_C1;
                    pos_nxt_s   = COLON1_POS;
                end else begin
                    pos_nxt_s   = COLON0_POS;
                end
            end
            ST_INIT_C1: begin
                if (xfer_s) begin
                    state_nxt_s = ST_LOAD;
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            ST_LOAD: begin
                if (pending_r == 6'b000000) begin
                    state_nxt_s = ST_IDLE;
                    valid_nxt_s = 1'b0;
                end else begin
                    // The bit is dropped when the digit is captured, so a
                    // strobe re-marking it while in flight forces a rewrite
                    // with the newer snapshot.
                    state_nxt_s = ST_SEND;
                    valid_nxt_s = 1'b1;
                    pos_nxt_s   = load_pos_s;
                    char_nxt_s  = load_char_s;
                    clr_bit_s   = load_bit_s;
                end
            end
            ST_SEND: begin
                if (xfer_s) begin
                    state_nxt_s = ST_LOAD;
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            ST_IDLE: begin
                valid_nxt_s = 1'b0;
                if ((pending_r != 6'b000000) ||
                    (i_time_wr_en && (i_time_sel != 6'b000000))) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_INIT_C0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Pending mask merge: captured digit cleared, new strobe bits added
    always_comb begin
        pending_nxt_s = pending_r & ~clr_bit_s;
        if (i_time_wr_en) begin
            pending_nxt_s = pending_nxt_s | i_time_sel;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // State, mask, snapshot and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_INIT_C0;
            pending_r  <= 6'b111111;
            snapshot_r <= 20'd0;
            valid_r    <= 1'b0;
            pos_r      <= '0;
            char_r     <= 8'h00;
            busy_r     <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
            valid_r   <= valid_nxt_s;
            pos_r     <= pos_nxt_s;
            char_r    <= char_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            if (i_time_wr_en) begin
                snapshot_r <= i_time_read_time;
            end
        end
    end

    assign o_lcd_valid = valid_r;
    assign o_lcd_pos   = pos_r;
    assign o_lcd_char  = char_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_time_digit_writer.sv
// Self-checking bench for time_digit_writer (COL_BASE=4, POS_W=4).
// Stimulus tasks push the expected character writes into a queue; a monitor
// pops and compares on every accepted transfer and checks that a stalled
// request holds its column and character.
module tb_time_digit_writer;

    localparam int COL_BASE = 4;
    localparam int POS_W    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [5:0]  sel = 6'd0;
    logic [19:0] tval = 20'd0;
    logic        busy;

    time_digit_writer_if #(.POS_W(POS_W)) lcd ();

    time_digit_writer #(.COL_BASE(COL_BASE), .POS_W(POS_W)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_time_wr_en     (wr_en),
        .i_time_sel       (sel),
        .i_time_read_time (tval),
        .i_lcd_ready      (lcd.ready),
        .o_lcd_valid      (lcd.valid),
        .o_lcd_pos        (lcd.pos),
        .o_lcd_char       (lcd.ch),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];          // pos*256 + char
    bit rand_rdy = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    // Reference tables indexed by digit number 0=S1 .. 5=H2
    int f_lsb[6] = '{0, 4, 7, 11, 14, 18};
    int f_wid[6] = '{4, 3, 4, 3, 4, 2};
    int c_ofs[6] = '{7, 6, 4, 3, 1, 0};

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic int ref_char(input int v, input bit is_h2);
        if (v > 9) return 8'h3F;
        if (is_h2 && BLANK && v == 0) return 8'h20;
        return 8'h30 + v;
    endfunction

    function automatic logic [19:0] pack(input int h2, h1, m2, m1, s2, s1);
        int t;
        t = s1 + (s2 << 4) + (m1 << 7) + (m2 << 11) + (h1 << 14) + (h2 << 18);
        return t[19:0];
    endfunction

    task automatic push_digits(input logic [5:0] s, input logic [19:0] t);
        for (int d = 5; d >= 0; d--) begin
            if (s[d]) begin
                int v;
                v = (int'(t) >> f_lsb[d]) & ((1 << f_wid[d]) - 1);
                exp_q.push_back((COL_BASE + c_ofs[d]) * 256 + ref_char(v, d == 5));
            end
        end
    endtask

    // Called at posedge+1; returns just after the capturing edge
    task automatic strobe(input logic [5:0] s, input logic [19:0] t);
        wr_en = 1'b1;
        sel   = s;
        tval  = t;
        push_digits(s, t);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        sel   = 6'd0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rand_rdy) lcd.ready = 1'($urandom_range(0, 1));
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout, busy=%0d, %0d writes outstanding", name, busy, exp_q.size());
        end
        @(posedge clk);
        #1;
        lcd.ready = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (lcd.valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: valid never rose", name);
        end
    endtask

    // Reset pulse: expected writes are discarded, then the power-up sequence queued
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(lcd.valid), 0);
        check("rst_pos",   int'(lcd.pos), 0);
        check("rst_char",  int'(lcd.ch), 0);
        check("rst_busy",  int'(busy), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back((COL_BASE + 2) * 256 + 8'h3A);
        exp_q.push_back((COL_BASE + 5) * 256 + 8'h3A);
        push_digits(6'h3F, 20'd0);
    endtask

    // Monitor: score accepted writes and check stall stability
    logic             hold_prev = 1'b0;
    logic [POS_W-1:0] prev_pos;
    logic [7:0]       prev_ch;
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", int'(lcd.valid), 1);
                check("hold_pos", int'(lcd.pos), int'(prev_pos));
                check("hold_char", int'(lcd.ch), int'(prev_ch));
            end
            if (lcd.valid && lcd.ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got pos %0d char 0x%0h, expected none",
                             lcd.pos, lcd.ch);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("write_pos", int'(lcd.pos), e / 256);
                    check("write_char", int'(lcd.ch), e % 256);
                end
                hold_prev = 1'b0;
            end else begin
                hold_prev = lcd.valid;
            end
            prev_pos = lcd.pos;
            prev_ch  = lcd.ch;
        end
    end

    initial begin
        lcd.ready = 1'b1;

        // Power-up: colons then all six digits of a zero snapshot
        do_reset();
        wait_idle("init_seq", 100);

        // Single S1 write and its two-cycle latency
        strobe(6'b000001, pack(0, 0, 0, 0, 0, 7));
        @(negedge clk);
        check("lat_load_valid", int'(lcd.valid), 0);
        @(negedge clk);
        check("lat_send_valid", int'(lcd.valid), 1);
        wait_idle("single_s1", 50);

        // Stalled S1 write overlapped by a new S2+S1 strobe
        lcd.ready = 1'b0;
        strobe(6'b000001, pack(0, 0, 0, 0, 0, 7));
        wait_valid("stall_first");
        @(posedge clk);
        #1;
        strobe(6'b000011, pack(0, 0, 0, 0, 1, 8));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_char", int'(lcd.ch), 8'h37);
        @(posedge clk);
        #1;
        lcd.ready = 1'b1;
        wait_idle("stall_overlap", 50);

        // Carry 23:59:59 -> 00:00:00
        strobe(6'h3F, pack(2, 3, 5, 9, 5, 9));
        wait_idle("show_235959", 80);
        strobe(6'h3F, pack(0, 0, 0, 0, 0, 0));
        wait_idle("carry_000000", 80);

        // Out-of-range field renders '?'
        strobe(6'b000110, pack(0, 0, 0, 12, 7, 0));
        wait_idle("unknown_char", 50);

        // Snapshot-only strobe produces no write
        strobe(6'b000000, pack(1, 2, 3, 4, 5, 6));
        @(negedge clk);
        check("sel0_busy", int'(busy), 0);
        @(negedge clk);
        check("sel0_valid", int'(lcd.valid), 0);
        @(posedge clk);
        #1;

        // Randomized times, masks and ready back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [5:0]  rs;
            logic [19:0] rt;
            rs = 6'($urandom_range(0, 63));
            rt = 20'($urandom);
            strobe(rs, rt);
            wait_idle("random", 200);
        end
        rand_rdy = 1'b0;

        // Reset while a write is stalled restarts the power-up sequence
        lcd.ready = 1'b0;
        strobe(6'b000001, pack(0, 0, 0, 0, 0, 5));
        wait_valid("pre_reset");
        do_reset();
        @(negedge clk);
        check("post_rst_valid", int'(lcd.valid), 0);
        @(posedge clk);
        #1;
        lcd.ready = 1'b1;
        wait_idle("reset_restart", 100);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
